program_loader: RTL
===================

Name: program_loader

Overview:
- Boot-time loader upstream of the CPU state controller.
- While the controller requests the size phase and then the data phase, it consumes bytes from the UART receiver, assembles 32-bit instruction words and writes them into instruction memory.
- Drives receive_program_data_size_finished and receive_program_data_finished back to the state controller.
- Idle once the program is loaded; ignores UART traffic during CPU execution.

Parameters:
- ADDR_WIDTH, 15, instruction memory word-address width; capacity is 2^ADDR_WIDTH words.
- BASE_ADDR, 0, word address of the first instruction written.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- receive_program_data_size  in  1  level enable from state controller: size phase active
- receive_program_data  in  1  level enable from state controller: data phase active
- rx_valid  in  1  one-cycle pulse, new UART byte available
- rx_data  in  8  received byte, valid when rx_valid=1
- receive_program_data_size_finished  out  1  size fully received (sticky)
- receive_program_data_finished  out  1  all program bytes written (sticky)
- imem_write_enable  out  1  one-cycle instruction memory write strobe
- imem_addr  out  ADDR_WIDTH  instruction memory word address
- imem_wdata  out  32  instruction word
- checksum_error  out  1  checksum mismatch flag (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; byte counter, size register, word shift register and address counter cleared. Reset mid-load aborts the load; partially written memory is not rolled back.
- IDLE:
  - -> SIZE when receive_program_data_size=1.
  - rx_valid is ignored in IDLE.
- SIZE:
  - Accepts 4 rx bytes, little-endian (first byte = bits 7:0). The value is the program length in bytes (32-bit unsigned).
  - On the 4th byte, size_finished is set from the next cycle and the FSM enters WAIT_DATA.
- WAIT_DATA:
  - -> DATA when receive_program_data=1.
  - If size==0, go directly to DONE with data_finished set; no writes.
- DATA:
  - Each accepted byte is shifted into the word register little-endian and increments the 32-bit byte count.
  - The cycle after the 4th byte of a word, or after the final byte (count==size): imem_write_enable=1 for exactly 1 cycle, imem_addr=BASE_ADDR+word_index, imem_wdata=assembled word. A partial final word is zero-padded in its upper bytes.
  - word_index increments after each write.
  - Addresses at or beyond 2^ADDR_WIDTH: the write strobe is suppressed; bytes are still counted so the phase still terminates.
- DONE:
  - data_finished is set the cycle after the final write strobe, or the final byte if that write was suppressed.
  - DONE holds until reset; rx_valid is ignored.
- Finished flags: sticky until reset, because the controller may stall while they are high.
- rx_valid arriving while the required enable is low (e.g. in WAIT_DATA before receive_program_data rises) is dropped.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss.
- The write strobe never overlaps the following byte's accept in a way that loses data: the word register is double-buffered.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, one extra rx byte is consumed in a CHECK state.
  - The 8-bit wrapping sum of all data bytes is compared with it.
  - On mismatch, checksum_error=1 (sticky).
  - data_finished is set only after the checksum byte, regardless of match.
- Undefined: no CHECK state; checksum_error tied 0.

Test Plan:
- Size bytes 08 00 00 00, then data 13 00 00 00 93 00 10 00 -> size_finished after 4th byte; writes addr0=0x00000013, addr1=0x00100093; data_finished 1 cycle after 2nd write.
- Size 06 00 00 00, data AA BB CC DD EE FF -> addr0=0xDDCCBBAA, addr1=0x0000FFEE; exactly 2 write strobes.
- Size 00 00 00 00 with receive_program_data asserted -> data_finished set, zero writes.
- Reset asserted after 5 of 8 data bytes -> all outputs 0 next cycle; a fresh full load then succeeds from addr 0.
- rx_valid pulses while both enables are low and after DONE -> no state change, no writes.
- With PROGRAM_LOADER_CHECKSUM_EN, size 04, data 01 02 03 04:
  - checksum 0A -> checksum_error=0.
  - checksum 0B -> checksum_error=1.
  - data_finished set after the checksum byte in both cases.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time program loader: receives a 32-bit little-endian byte count, then program bytes, and writes 32-bit words to instruction memory.
// Optional trailing 8-bit checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  receive_program_data_size,
    input  logic                  receive_program_data,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  receive_program_data_size_finished,
    output logic                  receive_program_data_finished,
    output logic                  imem_write_enable,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  checksum_error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SIZE      = 3'd1;
    localparam logic [2:0] S_WAIT_DATA = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd5;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK     = 3'd4;
`endif

    logic [2:0]  state;
    logic [1:0]  size_cnt;
    logic [31:0] size_reg;
    logic [31:0] byte_count;
    logic [31:0] word_reg;
    logic [31:0] word_index;

    logic        size_accept;
    logic        data_accept;
    logic [1:0]  lane;
    logic [31:0] byte_count_next;
    logic        last_byte;
    logic        word_full;
    logic [31:0] word_next;
    logic [32:0] full_addr;
    logic        addr_in_range;

    always_comb begin
        size_accept     = (state == S_SIZE) && rx_valid && receive_program_data_size;
        data_accept     = (state == S_DATA) && rx_valid && receive_program_data;
        lane            = byte_count[1:0];
        byte_count_next = byte_count + 32'd1;
        last_byte       = (byte_count_next == size_reg);
        word_full       = (lane == 2'd3) || last_byte;
        // A new word starts from zero so a short final word is zero-padded.
        word_next       = (lane == 2'd0) ? '0 : word_reg;
        word_next[{lane, 3'b000} +: 8] = rx_data;
        full_addr       = 33'(BASE_ADDR) + {1'b0, word_index};
        addr_in_range   = (full_addr[32:ADDR_WIDTH] == '0);
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       check_accept;

    always_comb begin
        check_accept = (state == S_CHECK) && rx_valid && receive_program_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state                              <= S_IDLE;
            size_cnt                           <= '0;
            size_reg                           <= '0;
            byte_count                         <= '0;
            word_reg                           <= '0;
            word_index                         <= '0;
            receive_program_data_size_finished <= 1'b0;
            receive_program_data_finished      <= 1'b0;
            imem_write_enable                  <= 1'b0;
            imem_addr                          <= '0;
            imem_wdata                         <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum                                <= '0;
            checksum_error                     <= 1'b0;
`endif
        end else begin
            imem_write_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (receive_program_data_size) state <= S_SIZE;
                end
                S_SIZE: begin
                    if (size_accept) begin
                        size_reg[{size_cnt, 3'b000} +: 8] <= rx_data;
                        size_cnt <= size_cnt + 2'd1;
                        if (size_cnt == 2'd3) begin
                            receive_program_data_size_finished <= 1'b1;
                            state <= S_WAIT_DATA;
                        end
                    end
                end
                S_WAIT_DATA: begin
                    if (receive_program_data) begin
                        if (size_reg == '0) begin
                            receive_program_data_finished <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (data_accept) begin
                        byte_count <= byte_count_next;
                        word_reg   <= word_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum        <= sum + rx_data;
`endif
                        // Output word is a separate register, so the next byte may arrive during the strobe.
                        if (word_full) begin
                            imem_write_enable <= addr_in_range;
                            imem_addr         <= full_addr[ADDR_WIDTH-1:0];
                            imem_wdata        <= word_next;
                            word_index        <= word_index + 32'd1;
                        end
                        if (last_byte) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state <= S_CHECK;
`else
                            state <= S_DONE;
                            if (!addr_in_range) receive_program_data_finished <= 1'b1;
`endif
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (check_accept) begin
                        if (rx_data != sum) checksum_error <= 1'b1;
                        receive_program_data_finished <= 1'b1;
                        state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    // Final strobe is visible this cycle; raise finished right after it.
                    if (imem_write_enable) receive_program_data_finished <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef PROGRAM_LOADER_CHECKSUM_EN
    assign checksum_error = 1'b0;
`endif

endmodule
